// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains LEN words from a non-FWFT FIFO onto a valid/ready stream.
// Define FIFO_BURST_READER_HEADER_EN to prepend a {2'b11, LEN} header beat to every burst.
module fifo_burst_reader #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned SKID_DEPTH = 4,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_q_i,
    output logic                  fifo_re_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  tx_last_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int unsigned PTR_W = $clog2(SKID_DEPTH);
    localparam int unsigned CNT_W = $clog2(SKID_DEPTH) + 2;
    localparam int unsigned TXL_W = LEN_WIDTH + 1;
`ifdef FIFO_BURST_READER_HEADER_EN
    localparam bit HEADER_EN = 1'b1;
`else
    localparam bit HEADER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    state_t                state_q;
    logic [LEN_WIDTH-1:0]  req_left_q, req_left_d;
    logic [TXL_W-1:0]      tx_left_q, tx_left_d;
    logic [RD_LATENCY-1:0] inflight_q;
    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d, occupancy;
    logic                  busy_q, done_q, hdr_q;
    logic [DATA_WIDTH-1:0] hdr_data_q;
    logic                  re, push, pop, beat;

    // Credit check counts words in flight plus buffered; same-cycle pops are not credited.
    always_comb begin
        occupancy  = count_q + CNT_W'($countones(inflight_q));
        re         = (state_q == READ) && (req_left_q != '0) && !fifo_empty_i &&
                     (occupancy < CNT_W'(SKID_DEPTH)) && !reset_i;
        push       = inflight_q[RD_LATENCY-1];
        beat       = tx_valid_o & tx_ready_i;
        pop        = beat & ~hdr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        req_left_d = req_left_q - LEN_WIDTH'(re);
        tx_left_d  = tx_left_q;
        if (beat && (tx_left_q != '0)) begin
            tx_left_d = tx_left_q - TXL_W'(1);
        end
    end

    assign fifo_re_o  = re;
    assign tx_valid_o = hdr_q | (count_q != '0);
    assign tx_data_o  = hdr_q ? hdr_data_q : mem_q[rd_ptr_q];
    assign tx_last_o  = tx_valid_o & (tx_left_q == TXL_W'(1));
    assign busy_o     = busy_q;
    assign done_o     = done_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            req_left_q <= '0;
            tx_left_q  <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hdr_q      <= 1'b0;
            hdr_data_q <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            inflight_q <= RD_LATENCY'({inflight_q, re});
            count_q    <= count_d;
            req_left_q <= req_left_d;
            tx_left_q  <= tx_left_d;
            if (push) begin
                mem_q[wr_ptr_q] <= fifo_q_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (beat) begin
                hdr_q <= 1'b0;
            end
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        req_left_q <= len_i;
                        tx_left_q  <= TXL_W'(len_i) + TXL_W'(HEADER_EN);
                        hdr_q      <= HEADER_EN;
                        hdr_data_q <= DATA_WIDTH'({2'b11, len_i});
                        busy_q     <= 1'b1;
                        if (len_i != '0) begin
                            state_q <= READ;
                        end else if (HEADER_EN) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (req_left_d == '0) begin
                        if (tx_left_d == '0) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (tx_left_d == '0) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The credit rule must make a write into a full skid buffer impossible.
    assert property (@(posedge clk_i) disable iff (reset_i)
                     !(push && (count_q == CNT_W'(SKID_DEPTH))));

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model with read latency, stream monitor and expected-burst model.
module tb_fifo_burst_reader;
    localparam int unsigned DW  = 18;
    localparam int unsigned LAT = 2;
    localparam int unsigned SD  = 4;
    localparam int unsigned LW  = 16;
`ifdef FIFO_BURST_READER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
        int            cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ready = 1'b0;
    logic [LW-1:0] len = '0;
    logic          fifo_empty, fifo_re, tx_valid, tx_last, busy, done;
    logic [DW-1:0] fifo_q, tx_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(DW), .RD_LATENCY(LAT), .SKID_DEPTH(SD), .LEN_WIDTH(LW)) dut (
        .clk_i(clk), .reset_i(rst), .start_i(start), .len_i(len),
        .fifo_empty_i(fifo_empty), .fifo_q_i(fifo_q), .fifo_re_o(fifo_re),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(ready),
        .tx_last_o(tx_last), .busy_o(busy), .done_o(done)
    );

    // Non-FWFT FIFO model: data appears LAT cycles after the accepted read.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] qp [LAT];
    int wr_cnt = 0;
    int rd_cnt = 0;
    assign fifo_empty = (wr_cnt == rd_cnt);
    assign fifo_q     = qp[LAT-1];

    always @(posedge clk) begin
        qp[0] <= mem[rd_cnt % 256];
        for (int i = 1; i < LAT; i++) qp[i] <= qp[i-1];
        if (fifo_re && !fifo_empty) rd_cnt <= rd_cnt + 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: sole writer of the observation logs below.
    beat_t         beats[$];
    int            re_cyc[$];
    int            done_cyc[$];
    int            re_empty_err = 0;
    int            stable_err = 0;
    int            issued = 0;
    int            accepted = 0;
    int            max_occ = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            issued = 0;
            accepted = 0;
            prev_stall = 1'b0;
        end else begin
            if (fifo_re) begin
                re_cyc.push_back(cyc);
                if (fifo_empty) re_empty_err++;
                issued++;
            end
            if (issued - accepted > max_occ) max_occ = issued - accepted;
            if (prev_stall && !(tx_valid && tx_data == prev_data)) stable_err++;
            if (tx_valid && ready) begin
                beats.push_back('{tx_data, tx_last, cyc});
                accepted++;
            end
            if (done) done_cyc.push_back(cyc);
            prev_stall = tx_valid && !ready;
            prev_data  = tx_data;
        end
    end

    int            start_cyc, base, cur_len;
    logic [DW-1:0] exp_q[$];

    task automatic fifo_write(input logic [DW-1:0] d);
        mem[wr_cnt % 256] = d;
        wr_cnt++;
    endtask

    task automatic do_start(input int l);
        @(posedge clk); #1;
        start = 1'b1;
        len = LW'(l);
        start_cyc = cyc;
        base = rd_cnt;
        cur_len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Expected burst: optional header, then the next cur_len words the FIFO held.
    task automatic build_exp();
        logic [DW-1:0] h;
        exp_q.delete();
        h = DW'({2'b11, LW'(cur_len)});
        for (int i = 0; i < HDR; i++) exp_q.push_back(h);
        for (int i = 0; i < cur_len; i++) exp_q.push_back(mem[(base + i) % 256]);
    endtask

    task automatic run_until_done(input int mode, input int budget, input int late_at,
                                  input int late_n, input int d0, output bit timeout);
        int extra = -1;
        timeout = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (mode == 1) ready = ~ready;
            else if (mode == 2) ready = ($urandom_range(0, 3) != 0);
            else ready = 1'b1;
            if (c == late_at) for (int k = 0; k < late_n; k++) fifo_write(DW'($urandom));
            if (done_cyc.size() > d0 && extra < 0) extra = 3;
            if (extra == 0) begin
                timeout = 1'b0;
                break;
            end
            if (extra > 0) extra--;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({fifo_re, tx_valid, tx_last, busy, done} !== 5'b0 || tx_data !== '0) begin
            failures++;
            $display("FAIL reset_hold: re/valid/last/busy/done=%b data=%h, want 0", {fifo_re, tx_valid, tx_last, busy, done}, tx_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({fifo_re, tx_valid, tx_last, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_release: outputs=%b, want 0", {fifo_re, tx_valid, tx_last, busy, done});
        end
    endtask

    task automatic test_full_rate();
        int b0, r0, d0, nb, got;
        bit to;
        for (int i = 0; i < 10; i++) fifo_write(DW'(i));
        ready = 1'b1;
        b0 = beats.size(); r0 = re_cyc.size(); d0 = done_cyc.size();
        do_start(8);
        run_until_done(0, 200, -1, 0, d0, to);
        build_exp();
        nb = beats.size() - b0;
        checks++;
        if (to) begin failures++; $display("FAIL full_rate_timeout: no DONE, want DONE"); end
        checks++;
        if (re_cyc.size() - r0 != 8) begin failures++; $display("FAIL full_rate_re_count: got %0d, want 8", re_cyc.size() - r0); end
        got = (re_cyc.size() > r0) ? re_cyc[r0] - start_cyc : -1;
        checks++;
        if (got != 1) begin failures++; $display("FAIL full_rate_first_re: cycle %0d, want 1", got); end
        got = (re_cyc.size() > r0) ? re_cyc[re_cyc.size()-1] - re_cyc[r0] : -1;
        checks++;
        if (got != 7) begin failures++; $display("FAIL full_rate_re_span: got %0d, want 7", got); end
        checks++;
        if (nb != exp_q.size()) begin failures++; $display("FAIL full_rate_beats: got %0d, want %0d", nb, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < nb; i++) begin
            checks++;
            if (beats[b0+i].d !== exp_q[i] || beats[b0+i].last !== (i == exp_q.size() - 1)) begin
                failures++;
                $display("FAIL full_rate_beat%0d: got %h last=%b, want %h last=%b", i, beats[b0+i].d, beats[b0+i].last, exp_q[i], i == exp_q.size() - 1);
            end
        end
        for (int i = 0; i < 8 && HDR + i < nb; i++) begin
            checks++;
            if (beats[b0+HDR+i].cyc - start_cyc != 4 + i) begin
                failures++;
                $display("FAIL full_rate_word%0d_cycle: got %0d, want %0d", i, beats[b0+HDR+i].cyc - start_cyc, 4 + i);
            end
        end
        got = (done_cyc.size() > d0 && nb > 0) ? done_cyc[d0] - beats[beats.size()-1].cyc : -1;
        checks++;
        if (done_cyc.size() - d0 != 1 || got != 1) begin
            failures++;
            $display("FAIL full_rate_done: count=%0d delay=%0d, want 1 and 1", done_cyc.size() - d0, got);
        end
        checks++;
        if (wr_cnt - rd_cnt != 2) begin failures++; $display("FAIL full_rate_left: got %0d words, want 2", wr_cnt - rd_cnt); end
    endtask

    task automatic test_backpressure();
        int b0, r0, d0, nb;
        bit to;
        for (int i = 0; i < 14; i++) fifo_write(DW'($urandom));
        ready = 1'b1;
        b0 = beats.size(); r0 = re_cyc.size(); d0 = done_cyc.size();
        do_start(16);
        run_until_done(1, 400, -1, 0, d0, to);
        build_exp();
        nb = beats.size() - b0;
        checks++;
        if (to || done_cyc.size() - d0 != 1) begin failures++; $display("FAIL backpressure_done: timeout=%0d dones=%0d, want 0 and 1", to, done_cyc.size() - d0); end
        checks++;
        if (re_cyc.size() - r0 != 16) begin failures++; $display("FAIL backpressure_re_count: got %0d, want 16", re_cyc.size() - r0); end
        checks++;
        if (nb != exp_q.size()) begin failures++; $display("FAIL backpressure_beats: got %0d, want %0d", nb, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < nb; i++) begin
            checks++;
            if (beats[b0+i].d !== exp_q[i] || beats[b0+i].last !== (i == exp_q.size() - 1)) begin
                failures++;
                $display("FAIL backpressure_beat%0d: got %h last=%b, want %h last=%b", i, beats[b0+i].d, beats[b0+i].last, exp_q[i], i == exp_q.size() - 1);
            end
        end
        checks++;
        if (stable_err != 0) begin failures++; $display("FAIL backpressure_stable: %0d changes while stalled, want 0", stable_err); end
        checks++;
        if (max_occ > SD) begin failures++; $display("FAIL backpressure_occupancy: max %0d, want <= %0d", max_occ, SD); end
    endtask

    task automatic test_underflow();
        int b0, r0, d0, nb, gap;
        bit to;
        for (int i = 0; i < 3; i++) fifo_write(DW'($urandom));
        ready = 1'b1;
        b0 = beats.size(); r0 = re_cyc.size(); d0 = done_cyc.size();
        do_start(6);
        run_until_done(0, 300, 20, 3, d0, to);
        build_exp();
        nb = beats.size() - b0;
        checks++;
        if (re_empty_err != 0) begin failures++; $display("FAIL underflow_re_empty: %0d reads while empty, want 0", re_empty_err); end
        checks++;
        if (to || done_cyc.size() - d0 != 1) begin failures++; $display("FAIL underflow_done: timeout=%0d dones=%0d, want 0 and 1", to, done_cyc.size() - d0); end
        checks++;
        if (re_cyc.size() - r0 != 6) begin failures++; $display("FAIL underflow_re_count: got %0d, want 6", re_cyc.size() - r0); end
        checks++;
        if (nb != exp_q.size()) begin failures++; $display("FAIL underflow_beats: got %0d, want %0d", nb, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < nb; i++) begin
            checks++;
            if (beats[b0+i].d !== exp_q[i] || beats[b0+i].last !== (i == exp_q.size() - 1)) begin
                failures++;
                $display("FAIL underflow_beat%0d: got %h last=%b, want %h last=%b", i, beats[b0+i].d, beats[b0+i].last, exp_q[i], i == exp_q.size() - 1);
            end
        end
        gap = (nb > HDR + 3) ? beats[b0+HDR+3].cyc - beats[b0+HDR+2].cyc : 0;
        checks++;
        if (gap < 10) begin failures++; $display("FAIL underflow_pause: gap after word 2 is %0d cycles, want >= 10", gap); end
    endtask

    task automatic test_zero_len_busy();
        int b0, r0, d0, got;
        bit to;
        ready = 1'b1;
        b0 = beats.size(); r0 = re_cyc.size(); d0 = done_cyc.size();
        do_start(0);
        run_until_done(0, 50, -1, 0, d0, to);
        got = (done_cyc.size() > d0) ? done_cyc[d0] - start_cyc : -1;
        checks++;
        if (to || done_cyc.size() - d0 != 1 || got != 1 + HDR) begin
            failures++;
            $display("FAIL zero_len_done: count=%0d cycle=%0d, want 1 and %0d", done_cyc.size() - d0, got, 1 + HDR);
        end
        checks++;
        if (re_cyc.size() != r0 || beats.size() - b0 != HDR) begin
            failures++;
            $display("FAIL zero_len_activity: reads=%0d beats=%0d, want 0 and %0d", re_cyc.size() - r0, beats.size() - b0, HDR);
        end
        for (int i = 0; i < 8; i++) fifo_write(DW'($urandom));
        b0 = beats.size(); r0 = re_cyc.size(); d0 = done_cyc.size();
        do_start(2);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_high: got %b, want 1", busy); end
        start = 1'b1;
        len = LW'(5);
        @(posedge clk); #1;
        start = 1'b0;
        run_until_done(0, 100, -1, 0, d0, to);
        repeat (10) @(posedge clk);
        build_exp();
        checks++;
        if (done_cyc.size() - d0 != 1 || re_cyc.size() - r0 != 2) begin
            failures++;
            $display("FAIL busy_ignore: dones=%0d reads=%0d, want 1 and 2", done_cyc.size() - d0, re_cyc.size() - r0);
        end
        checks++;
        if (beats.size() - b0 != exp_q.size() || beats[beats.size()-1].d !== exp_q[exp_q.size()-1]) begin
            failures++;
            $display("FAIL busy_ignore_beats: got %0d ending %h, want %0d ending %h", beats.size() - b0, beats[beats.size()-1].d, exp_q.size(), exp_q[exp_q.size()-1]);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_low: got %b, want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int b0, d0, nb;
        bit to, hit;
        for (int i = 0; i < 40; i++) fifo_write(DW'($urandom));
        ready = 1'b1;
        b0 = beats.size(); d0 = done_cyc.size();
        do_start(32);
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (beats.size() - b0 == 4 && tx_valid) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL reset_mid_reach: no 5th transfer, want one"); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_re !== 1'b0) begin failures++; $display("FAIL reset_mid_re: got %b in reset cycle, want 0", fifo_re); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({fifo_re, tx_valid, tx_last, busy, done} !== 5'b0 || tx_data !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: re/valid/last/busy/done=%b data=%h, want 0", {fifo_re, tx_valid, tx_last, busy, done}, tx_data);
        end
        repeat (8) @(posedge clk);
        checks++;
        if (done_cyc.size() != d0) begin failures++; $display("FAIL reset_mid_no_done: got %0d dones, want 0", done_cyc.size() - d0); end
        b0 = beats.size(); d0 = done_cyc.size();
        do_start(4);
        run_until_done(0, 100, -1, 0, d0, to);
        build_exp();
        nb = beats.size() - b0;
        checks++;
        if (to || nb != exp_q.size()) begin failures++; $display("FAIL reset_mid_restart: timeout=%0d beats=%0d, want 0 and %0d", to, nb, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < nb; i++) begin
            checks++;
            if (beats[b0+i].d !== exp_q[i] || beats[b0+i].last !== (i == exp_q.size() - 1)) begin
                failures++;
                $display("FAIL reset_mid_beat%0d: got %h last=%b, want %h last=%b", i, beats[b0+i].d, beats[b0+i].last, exp_q[i], i == exp_q.size() - 1);
            end
        end
    endtask

    task automatic test_random();
        int b0, r0, d0, nb, l, n0;
        bit to;
        for (int it = 0; it < 6; it++) begin
            l  = $urandom_range(1, 20);
            n0 = $urandom_range(0, l);
            for (int i = 0; i < n0; i++) fifo_write(DW'($urandom));
            ready = 1'b1;
            b0 = beats.size(); r0 = re_cyc.size(); d0 = done_cyc.size();
            do_start(l);
            run_until_done(2, 600, $urandom_range(0, 15), l - n0, d0, to);
            build_exp();
            nb = beats.size() - b0;
            checks++;
            if (to || done_cyc.size() - d0 != 1 || re_cyc.size() - r0 != l) begin
                failures++;
                $display("FAIL random%0d_done: timeout=%0d dones=%0d reads=%0d, want 0 1 %0d", it, to, done_cyc.size() - d0, re_cyc.size() - r0, l);
            end
            checks++;
            if (nb != exp_q.size()) begin failures++; $display("FAIL random%0d_beats: got %0d, want %0d", it, nb, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < nb; i++) begin
                checks++;
                if (beats[b0+i].d !== exp_q[i] || beats[b0+i].last !== (i == exp_q.size() - 1)) begin
                    failures++;
                    $display("FAIL random%0d_beat%0d: got %h last=%b, want %h last=%b", it, i, beats[b0+i].d, beats[b0+i].last, exp_q[i], i == exp_q.size() - 1);
                end
            end
        end
        checks++;
        if (stable_err != 0 || re_empty_err != 0 || max_occ > SD) begin
            failures++;
            $display("FAIL random_invariants: stable=%0d re_empty=%0d max_occ=%0d, want 0 0 <=%0d", stable_err, re_empty_err, max_occ, SD);
        end
    endtask

`ifdef FIFO_BURST_READER_HEADER_EN
    task automatic test_header();
        int b0, d0, nb;
        bit to;
        for (int i = 0; i < 3; i++) fifo_write(DW'(100 + i));
        ready = 1'b1;
        b0 = beats.size(); d0 = done_cyc.size();
        do_start(3);
        run_until_done(0, 100, -1, 0, d0, to);
        nb = beats.size() - b0;
        checks++;
        if (to || nb != 4) begin failures++; $display("FAIL header_len3_count: timeout=%0d beats=%0d, want 0 and 4", to, nb); end
        checks++;
        if (nb < 4 || beats[b0].d !== 18'h30003 || beats[b0].last !== 1'b0 || beats[b0+3].last !== 1'b1) begin
            failures++;
            $display("FAIL header_len3: first=%h last0=%b last3=%b, want 30003 0 1", beats[b0].d, beats[b0].last, beats[beats.size()-1].last);
        end
        b0 = beats.size(); d0 = done_cyc.size();
        do_start(0);
        run_until_done(0, 50, -1, 0, d0, to);
        nb = beats.size() - b0;
        checks++;
        if (to || nb != 1 || beats[b0].d !== 18'h30000 || beats[b0].last !== 1'b1) begin
            failures++;
            $display("FAIL header_len0: beats=%0d data=%h last=%b, want 1 30000 1", nb, beats[beats.size()-1].d, beats[beats.size()-1].last);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_underflow();
        test_zero_len_busy();
        test_reset_mid();
        test_random();
`ifdef FIFO_BURST_READER_HEADER_EN
        test_header();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side controller for the 18-bit, 64K-deep synchronous sample FIFO. It is non-FWFT: Q is valid a fixed number of cycles after RE, and reads while EMPTY are ignored. On a START command the block drains exactly LEN words from the FIFO. It hides the FIFO read latency behind a small credit-controlled skid buffer and presents the words on a valid/ready stream with TX_LAST marking the final word. It sits between the acquisition FIFO and the downstream transmit/packet interface.

Parameters:
DATA_WIDTH, 18, width of FIFO_Q and TX_DATA
RD_LATENCY, 2, cycles from FIFO_RE high to the corresponding word on FIFO_Q (must be 1..4)
SKID_DEPTH, 4, skid buffer entries; must be a power of 2 and >= RD_LATENCY+2 for full throughput
LEN_WIDTH, 16, width of LEN and of the word counters

Ports:
CLK  in  1  the one and only clock; all logic is on the rising edge
RESET  in  1  reset, synchronous and active-high
START  in  1  one-cycle burst request; sampled only in IDLE
LEN  in  LEN_WIDTH  burst length in words; sampled with START
FIFO_EMPTY  in  1  FIFO EMPTY flag
FIFO_Q  in  DATA_WIDTH  FIFO read data
FIFO_RE  out  1  FIFO read enable, active-high
TX_DATA  out  DATA_WIDTH  stream data
TX_VALID  out  1  stream valid
TX_READY  in  1  stream ready from the consumer
TX_LAST  out  1  high with the final word of the burst
BUSY  out  1  high from the accepted START until DONE
DONE  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset values: FIFO_RE=0, TX_VALID=0, TX_LAST=0, TX_DATA=0, BUSY=0, DONE=0, state=IDLE. Reset also clears the skid buffer, the in-flight shift register and all counters.
- RESET mid-burst: the burst is dropped with no DONE pulse. Words already read from the FIFO are lost, and no FIFO_RE is issued in the reset cycle.
- State IDLE:
  - START=1 latches LEN into req_left and tx_left, sets BUSY on the next edge, and moves to READ.
  - START while not in IDLE is ignored.
  - START with LEN=0 moves to FINISH directly: DONE pulses 1 cycle later, and no FIFO_RE or TX beat occurs.
- State READ:
  - FIFO_RE = (req_left!=0) & !FIFO_EMPTY & (skid_count + inflight_count < SKID_DEPTH). This is combinational from registered state plus FIFO_EMPTY.
  - Each FIFO_RE decrements req_left and enters a RD_LATENCY-deep valid shift register.
  - When the shift register outputs 1, FIFO_Q is written into the skid buffer.
  - Words popped in the same cycle are not credited; they free space one cycle later (conservative credit rule).
  - Occupancy can therefore never exceed SKID_DEPTH; write-on-full is impossible by construction and is covered by an assertion.
  - When req_left reaches 0, move to DRAIN.
- State DRAIN: no FIFO_RE. Wait until tx_left reaches 0, then go to FINISH.
- State FINISH: DONE=1 for exactly one cycle, BUSY falls on the same edge, and the next state is IDLE.
- Output stream:
  - TX_VALID = skid buffer not empty; TX_DATA is the head entry.
  - A transfer occurs when TX_VALID & TX_READY; it pops the head and decrements tx_left.
  - TX_LAST = TX_VALID & (tx_left==1).
  - TX_DATA and TX_VALID must hold stable while TX_VALID & !TX_READY.
  - Simultaneous push and pop in one cycle is supported; occupancy is unchanged.
- Latency: START at cycle 0 with FIFO non-empty gives FIFO_RE at cycle 1. The word is captured at cycle 1+RD_LATENCY, and TX_VALID is high at cycle 2+RD_LATENCY.
- Throughput: with TX_READY held high and the FIFO non-empty, one word per cycle is sustained.
- FIFO_EMPTY mid-burst: reading stalls, the burst is not aborted, and reading resumes when EMPTY falls.
- Pointers: the skid buffer pointers wrap modulo SKID_DEPTH. req_left and tx_left never wrap below 0.

Optional Feature:
FIFO_BURST_READER_HEADER_EN.
- Defined: each burst is preceded by one header beat, TX_DATA = {2'b11, LEN[15:0]} (upper bits zero if DATA_WIDTH>18).
  - The header is emitted from a separate register before the first skid word, and tx_left counts LEN+1 beats.
  - TX_LAST is never set on the header unless LEN=0; in that case the header alone is sent with TX_LAST=1, followed by DONE.
  - FIFO reads may start while the header is pending.
- Undefined: there are no header beats, and LEN=0 produces DONE only.

Test Plan:
1. Full-rate burst: FIFO pre-filled with 0..9, TX_READY=1, START with LEN=8 → FIFO_RE high for 8 consecutive cycles from cycle 1. TX_DATA is 0..7 on consecutive cycles starting at cycle 4, TX_LAST on word 7, a DONE pulse one cycle after the last transfer, and 2 words left in the FIFO.
2. Backpressure: LEN=16, TX_READY toggling 1/0 each cycle → no word is lost or duplicated, and TX_DATA holds stable while stalled. Total FIFO_RE count is exactly 16, and in-flight plus skid occupancy never exceeds 4.
3. Underflow stall: FIFO holds 3 words, LEN=6, 3 more words written 20 cycles later → FIFO_RE is never high while FIFO_EMPTY=1, the stream pauses after word 2, and the burst completes with 6 words and one DONE.
4. Zero length and busy: START with LEN=0 → DONE 1 cycle later and no FIFO_RE. A second START while BUSY is ignored: one DONE only.
5. Reset mid-burst: RESET asserted at the 5th transfer of a LEN=32 burst → the next cycle shows all outputs at reset values and no DONE. A new START with LEN=4 then works normally.
6. With FIFO_BURST_READER_HEADER_EN defined: LEN=3 → first beat is 0x30003, then 3 data words, TX_LAST on the 4th beat. LEN=0 gives the single beat 0x30000 with TX_LAST=1.
